imm_stage: RTL and testbench
============================

Name: imm_stage

Overview:
Pipelined, parametrised immediate-generation stage placed between fetch/decode and execute. It accepts one 32-bit instruction per cycle over a valid/ready handshake and returns the sign- or zero-extended immediate at XLEN width one cycle later. A 2-entry skid buffer preserves full throughput under backpressure. The stage adds CSR-zimm and shift-amount formats, an optional opcode-driven auto-decode mode and an illegal flag.

Parameters:
XLEN, 32, datapath width of out_imm; legal values are 32 and 64 only. Any other value fails elaboration.
AUTO_DECODE, 0, 0: format taken from in_imm_src. 1: format derived from opcode and funct3, and in_imm_src is ignored.
CNT_W, 16, width of the transfer counter.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  upstream instruction valid
in_ready  output  1  stage can accept
in_instr  input  32  instruction word
in_imm_src  input  3  format select (manual mode)
out_valid  output  1  result valid
out_ready  input  1  downstream accepts
out_imm  output  XLEN  extended immediate
out_fmt  output  3  format code actually applied
out_illegal  output  1  format unresolvable
out_count  output  CNT_W  number of completed output transfers

Behaviour:
- One clock, clk. reset is asynchronous and active-high.
- While reset is asserted: out_valid=0, out_imm=0, out_fmt=0, out_illegal=0, out_count=0, skid empty.
- in_ready=1 from the first cycle after reset deassertion.
- Format codes, with s = sign-extend to XLEN:
  - 000 I: s(instr[31:20])
  - 001 S: s({[31:25],[11:7]})
  - 010 B: s({[31],[7],[30:25],[11:8],0})
  - 011 U: s({[31:12],12'b0}). For XLEN=64, bit 31 is replicated to bits 63:32.
  - 100 J: s({[31],[19:12],[20],[30:21],0})
  - 101 Z: zero-extend instr[19:15]
  - 110 SH: zero-extend instr[24:20] when XLEN=32, instr[25:20] when XLEN=64
  - 111: imm=0 with out_illegal=1 in manual mode
- AUTO_DECODE=1 mapping from opcode instr[6:0]:
  - 0000011, 1100111: I
  - 0010011: SH if funct3 is 001 or 101, else I
  - 1110011: Z if funct3[2]=1, else I
  - 0100011: S
  - 1100011: B
  - 0110111, 0010111: U
  - 1101111: J
  - 0110011: fmt 111, imm 0, illegal 0 (R-type has no immediate)
  - any other opcode: fmt 111, imm 0, illegal 1
- Handshake:
  - Input transfer occurs when in_valid & in_ready. Output transfer occurs when out_valid & out_ready.
  - Latency is exactly 1 cycle: data accepted at edge N is presented with out_valid=1 after edge N.
  - Full throughput: one instruction per cycle while out_ready=1.
  - Output register states: EMPTY, FULL, FULL+SKID.
  - EMPTY + input → FULL.
  - FULL + output transfer + input → FULL with new data.
  - FULL + output transfer, no input → EMPTY.
  - FULL + no output transfer + input → FULL+SKID. The input is captured in skid; in_ready=0 next cycle.
  - FULL+SKID + output transfer → FULL. Skid data moves to the output; in_ready=1 next cycle.
- in_ready is a registered signal equal to the inverse of skid-occupied. It has no combinational path from out_ready.
- out_imm, out_fmt and out_illegal are held stable while out_valid=1 and out_ready=0.
- out_count increments by 1 per output transfer and wraps from 2^CNT_W-1 to 0.
- Reset mid-operation discards both entries immediately. No partial transfer completes.
- X-free: all outputs are defined every cycle, including when out_valid=0. When out_valid=0, out_imm holds its last value.

Test Plan:
- XLEN=32 manual mode, out_ready=1. Send 0xFFF00093/000, 0xFE112E23/001, 0xFE000CE3/010 and 0x123452B7/011 back to back → out_imm 0xFFFFFFFF, 0xFFFFFFFC, 0xFFFFFFF8, 0x12345000 on four consecutive cycles, each 1 cycle after its input; out_count=4.
- XLEN=64 AUTO_DECODE=1. Send 0x800002B7 (lui) → 0xFFFFFFFF80000000 with fmt 011. Send 0x03F09093 (slli 63) → 0x000000000000003F with fmt 110. Send 0x0007D073 (csrrwi, zimm=15) → 0xF with fmt 101.
- Backpressure: hold out_ready=0, drive in_valid=1 with three instructions → two accepted, in_ready=0 from the cycle after the second. Raise out_ready → outputs emerge in order, no drop or duplicate, in_ready returns to 1.
- Illegal: manual in_imm_src=111 → imm 0, illegal 1. AUTO_DECODE=1 with opcode 0x7F → fmt 111, illegal 1. Opcode 0110011 → illegal 0.
- Assert reset while FULL+SKID → out_valid=0 and out_count=0 immediately. in_ready=1 one cycle after release. The first post-reset input yields correct output 1 cycle later.
- With CNT_W=4, perform 17 output transfers → out_count reads 1.

Source files
------------

// File: rtl/imm_stage.sv
// ============================================================================
// imm_stage : pipelined immediate generator with valid/ready and 2-entry skid
// Rev 1.0
// ============================================================================
`default_nettype none

module imm_stage #(
    parameter int XLEN        = 32,
    parameter bit AUTO_DECODE = 1'b0,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_imm_src,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [CNT_W-1:0] out_count
);

    if (XLEN != 32 && XLEN != 64) begin : g_xlen_check
        $error("imm_stage: XLEN must be 32 or 64");
    end

    localparam logic [2:0] FMT_I    = 3'd0;
    localparam logic [2:0] FMT_S    = 3'd1;
    localparam logic [2:0] FMT_B    = 3'd2;
    localparam logic [2:0] FMT_U    = 3'd3;
    localparam logic [2:0] FMT_J    = 3'd4;
    localparam logic [2:0] FMT_Z    = 3'd5;
    localparam logic [2:0] FMT_SH   = 3'd6;
    localparam logic [2:0] FMT_NONE = 3'd7;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [2:0]      dec_fmt;
    logic            dec_illegal;
    logic [31:0]     imm32;
    logic [XLEN-1:0] dec_imm;

    state_t          state;
    logic [XLEN-1:0] skid_imm;
    logic [2:0]      skid_fmt;
    logic            skid_illegal;
    logic            in_fire;
    logic            out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        opcode      = in_instr[6:0];
        funct3      = in_instr[14:12];
        dec_fmt     = in_imm_src;
        dec_illegal = (in_imm_src == FMT_NONE);
        imm32       = 32'd0;

        if (AUTO_DECODE) begin
            dec_fmt     = FMT_NONE;
            dec_illegal = 1'b1;
            case (opcode)
                OP_LOAD, OP_JALR: begin dec_fmt = FMT_I; dec_illegal = 1'b0; end
                OP_IMM: begin
                    dec_fmt     = (funct3 == 3'b001 || funct3 == 3'b101) ? FMT_SH : FMT_I;
                    dec_illegal = 1'b0;
                end
                OP_SYSTEM: begin
                    dec_fmt     = funct3[2] ? FMT_Z : FMT_I;
                    dec_illegal = 1'b0;
                end
                OP_STORE:         begin dec_fmt = FMT_S; dec_illegal = 1'b0; end
                OP_BRANCH:        begin dec_fmt = FMT_B; dec_illegal = 1'b0; end
                OP_LUI, OP_AUIPC: begin dec_fmt = FMT_U; dec_illegal = 1'b0; end
                OP_JAL:           begin dec_fmt = FMT_J; dec_illegal = 1'b0; end
                // R-type: no immediate, but a perfectly legal instruction
                OP_REG:           begin dec_fmt = FMT_NONE; dec_illegal = 1'b0; end
                default:          begin dec_fmt = FMT_NONE; dec_illegal = 1'b1; end
            endcase
        end

        // Every format is built as a 32-bit signed value, then widened to XLEN
        case (dec_fmt)
            FMT_I:  imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            FMT_S:  imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            FMT_B:  imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                             in_instr[30:25], in_instr[11:8], 1'b0};
            FMT_U:  imm32 = {in_instr[31:12], 12'd0};
            FMT_J:  imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                             in_instr[20], in_instr[30:21], 1'b0};
            FMT_Z:  imm32 = {27'd0, in_instr[19:15]};
            FMT_SH: imm32 = (XLEN == 64) ? {26'd0, in_instr[25:20]}
                                         : {27'd0, in_instr[24:20]};
            default: imm32 = 32'd0;
        endcase

        dec_imm = XLEN'($signed(imm32));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_EMPTY;
            in_ready     <= 1'b0;
            out_valid    <= 1'b0;
            out_imm      <= '0;
            out_fmt      <= 3'd0;
            out_illegal  <= 1'b0;
            skid_imm     <= '0;
            skid_fmt     <= 3'd0;
            skid_illegal <= 1'b0;
            out_count    <= '0;
        end else begin
            in_ready <= 1'b1;
            if (out_fire) begin
                out_count <= out_count + CNT_W'(1);
            end

            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        out_imm     <= dec_imm;
                        out_fmt     <= dec_fmt;
                        out_illegal <= dec_illegal;
                        out_valid   <= 1'b1;
                        state       <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        if (in_fire) begin
                            out_imm     <= dec_imm;
                            out_fmt     <= dec_fmt;
                            out_illegal <= dec_illegal;
                        end else begin
                            out_valid <= 1'b0;
                            state     <= ST_EMPTY;
                        end
                    end else if (in_fire) begin
                        skid_imm     <= dec_imm;
                        skid_fmt     <= dec_fmt;
                        skid_illegal <= dec_illegal;
                        in_ready     <= 1'b0;
                        state        <= ST_SKID;
                    end
                end
                ST_SKID: begin
                    // in_ready is low here, so no new input can arrive
                    if (out_fire) begin
                        out_imm     <= skid_imm;
                        out_fmt     <= skid_fmt;
                        out_illegal <= skid_illegal;
                        state       <= ST_FULL;
                    end else begin
                        in_ready <= 1'b0;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= ST_EMPTY;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_imm_stage.sv
// ============================================================================
// tb_imm_stage : table-driven scoreboard bench for imm_stage (three configs)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_imm_stage;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  src;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // a: XLEN=32 manual, b: XLEN=64 auto-decode, c: XLEN=32 manual CNT_W=4
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_illegal;
    logic [31:0] a_in_instr, a_out_imm;
    logic [2:0]  a_in_imm_src, a_out_fmt;
    logic [15:0] a_out_count;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_illegal;
    logic [31:0] b_in_instr;
    logic [63:0] b_out_imm;
    logic [2:0]  b_in_imm_src, b_out_fmt;
    logic [15:0] b_out_count;

    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_illegal;
    logic [31:0] c_in_instr, c_out_imm;
    logic [2:0]  c_in_imm_src, c_out_fmt;
    logic [3:0]  c_out_count;

    imm_stage #(.XLEN(32), .AUTO_DECODE(1'b0), .CNT_W(16)) u_a (
        .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_instr(a_in_instr), .in_imm_src(a_in_imm_src), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_imm(a_out_imm), .out_fmt(a_out_fmt),
        .out_illegal(a_out_illegal), .out_count(a_out_count));

    imm_stage #(.XLEN(64), .AUTO_DECODE(1'b1), .CNT_W(16)) u_b (
        .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_instr(b_in_instr), .in_imm_src(b_in_imm_src), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_imm(b_out_imm), .out_fmt(b_out_fmt),
        .out_illegal(b_out_illegal), .out_count(b_out_count));

    imm_stage #(.XLEN(32), .AUTO_DECODE(1'b0), .CNT_W(4)) u_c (
        .clk(clk), .reset(reset), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_instr(c_in_instr), .in_imm_src(c_in_imm_src), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .out_imm(c_out_imm), .out_fmt(c_out_fmt),
        .out_illegal(c_out_illegal), .out_count(c_out_count));

    int   checks = 0;
    int   errors = 0;
    vec_t qa[$];
    vec_t qb[$];
    vec_t qc[$];
    vec_t tab_a[10];
    vec_t tab_b[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] i, input logic [2:0] s,
                                input logic [63:0] m, input logic [2:0] f, input logic l);
        vec_t v;
        v.instr = i; v.src = s; v.imm = m; v.fmt = f; v.ill = l;
        return v;
    endfunction

    function automatic logic rdy(input int d);
        case (d)
            0:       return a_in_ready;
            1:       return b_in_ready;
            default: return c_in_ready;
        endcase
    endfunction

    // Holds the vector on the input until accepted; returns just after the accepting edge
    task automatic send(input int d, input vec_t v);
        bit ok;
        ok = 1'b0;
        case (d)
            0: begin a_in_valid = 1'b1; a_in_instr = v.instr; a_in_imm_src = v.src; end
            1: begin b_in_valid = 1'b1; b_in_instr = v.instr; b_in_imm_src = v.src; end
            default: begin c_in_valid = 1'b1; c_in_instr = v.instr; c_in_imm_src = v.src; end
        endcase
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (rdy(d)) begin
                ok = 1'b1;
                case (d)
                    0:       qa.push_back(v);
                    1:       qb.push_back(v);
                    default: qc.push_back(v);
                endcase
            end
            @(posedge clk);
            #1;
        end
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        c_in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout dut=%0d instr=%h", d, v.instr);
        end
    endtask

    always @(negedge clk) begin
        vec_t e;
        if (!reset && a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_a_extra actual=%h required=none", a_out_imm);
            end else begin
                e = qa.pop_front();
                chk("sb_a_imm", 64'(a_out_imm), {32'd0, e.imm[31:0]});
                chk("sb_a_fmt", 64'(a_out_fmt), 64'(e.fmt));
                chk("sb_a_ill", 64'(a_out_illegal), 64'(e.ill));
            end
        end
    end

    always @(negedge clk) begin
        vec_t e;
        if (!reset && b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_b_extra actual=%h required=none", b_out_imm);
            end else begin
                e = qb.pop_front();
                chk("sb_b_imm", b_out_imm, e.imm);
                chk("sb_b_fmt", 64'(b_out_fmt), 64'(e.fmt));
                chk("sb_b_ill", 64'(b_out_illegal), 64'(e.ill));
            end
        end
    end

    always @(negedge clk) begin
        vec_t e;
        if (!reset && c_out_valid && c_out_ready) begin
            if (qc.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_c_extra actual=%h required=none", c_out_imm);
            end else begin
                e = qc.pop_front();
                chk("sb_c_imm", 64'(c_out_imm), {32'd0, e.imm[31:0]});
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tab_a[0] = mk(32'hFFF00093, 3'd0, 64'h0000_0000_FFFF_FFFF, 3'd0, 1'b0);
        tab_a[1] = mk(32'hFE112E23, 3'd1, 64'h0000_0000_FFFF_FFFC, 3'd1, 1'b0);
        tab_a[2] = mk(32'hFE000CE3, 3'd2, 64'h0000_0000_FFFF_FFF8, 3'd2, 1'b0);
        tab_a[3] = mk(32'h123452B7, 3'd3, 64'h0000_0000_1234_5000, 3'd3, 1'b0);
        tab_a[4] = mk(32'h8000006F, 3'd4, 64'h0000_0000_FFF0_0000, 3'd4, 1'b0);
        tab_a[5] = mk(32'h0007D073, 3'd5, 64'h0000_0000_0000_000F, 3'd5, 1'b0);
        tab_a[6] = mk(32'h03F09093, 3'd6, 64'h0000_0000_0000_001F, 3'd6, 1'b0);
        tab_a[7] = mk(32'hFFFFFFFF, 3'd7, 64'h0000_0000_0000_0000, 3'd7, 1'b1);
        tab_a[8] = mk(32'h00100093, 3'd0, 64'h0000_0000_0000_0001, 3'd0, 1'b0);
        tab_a[9] = mk(32'h00001017, 3'd3, 64'h0000_0000_0000_1000, 3'd3, 1'b0);

        // in_imm_src=7 throughout: auto mode must ignore it
        tab_b[0]  = mk(32'h800002B7, 3'd7, 64'hFFFF_FFFF_8000_0000, 3'd3, 1'b0);
        tab_b[1]  = mk(32'h03F09093, 3'd7, 64'h0000_0000_0000_003F, 3'd6, 1'b0);
        tab_b[2]  = mk(32'h0007D073, 3'd7, 64'h0000_0000_0000_000F, 3'd5, 1'b0);
        tab_b[3]  = mk(32'h0000007F, 3'd7, 64'h0000_0000_0000_0000, 3'd7, 1'b1);
        tab_b[4]  = mk(32'h00000033, 3'd7, 64'h0000_0000_0000_0000, 3'd7, 1'b0);
        tab_b[5]  = mk(32'hFFF00093, 3'd7, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 1'b0);
        tab_b[6]  = mk(32'hFE112E23, 3'd7, 64'hFFFF_FFFF_FFFF_FFFC, 3'd1, 1'b0);
        tab_b[7]  = mk(32'hFE000CE3, 3'd7, 64'hFFFF_FFFF_FFFF_FFF8, 3'd2, 1'b0);
        tab_b[8]  = mk(32'h8000006F, 3'd7, 64'hFFFF_FFFF_FFF0_0000, 3'd4, 1'b0);
        tab_b[9]  = mk(32'hFFF00003, 3'd7, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 1'b0);
        tab_b[10] = mk(32'h00000073, 3'd7, 64'h0000_0000_0000_0000, 3'd0, 1'b0);
        tab_b[11] = mk(32'h41F0D093, 3'd7, 64'h0000_0000_0000_001F, 3'd6, 1'b0);
        tab_b[12] = mk(32'h00001017, 3'd7, 64'h0000_0000_0000_1000, 3'd3, 1'b0);

        reset = 1'b1;
        a_in_valid = 1'b0; a_in_instr = 32'd0; a_in_imm_src = 3'd0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_instr = 32'd0; b_in_imm_src = 3'd0; b_out_ready = 1'b1;
        c_in_valid = 1'b0; c_in_instr = 32'd0; c_in_imm_src = 3'd0; c_out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_valid", 64'(a_out_valid), 64'd0);
        chk("rst_a_imm",   64'(a_out_imm),   64'd0);
        chk("rst_a_fmt",   64'(a_out_fmt),   64'd0);
        chk("rst_a_ill",   64'(a_out_illegal), 64'd0);
        chk("rst_a_count", 64'(a_out_count), 64'd0);
        chk("rst_b_imm",   b_out_imm,        64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rdy_after_reset", 64'(a_in_ready), 64'd1);

        // Manual XLEN=32 stream, one cycle latency each
        for (int i = 0; i < 10; i++) begin
            send(0, tab_a[i]);
            chk("lat_a_valid", 64'(a_out_valid), 64'd1);
            chk("lat_a_imm", 64'(a_out_imm), {32'd0, tab_a[i].imm[31:0]});
            if (i == 3) begin
                @(posedge clk);
                #1;
                chk("count_after_4", 64'(a_out_count), 64'd4);
            end
        end
        @(posedge clk);
        #1;
        chk("idle_valid", 64'(a_out_valid), 64'd0);
        chk("idle_hold_imm", 64'(a_out_imm), {32'd0, tab_a[9].imm[31:0]});

        // Auto-decode XLEN=64 stream
        for (int i = 0; i < 13; i++) begin
            send(1, tab_b[i]);
            chk("lat_b_imm", b_out_imm, tab_b[i].imm);
            chk("lat_b_fmt", 64'(b_out_fmt), 64'(tab_b[i].fmt));
        end

        // Backpressure: two accepted, third stalls until skid drains
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_instr = tab_a[0].instr; a_in_imm_src = tab_a[0].src;
        @(negedge clk);
        chk("bp_rdy0", 64'(a_in_ready), 64'd1);
        qa.push_back(tab_a[0]);
        @(posedge clk);
        #1;
        a_in_instr = tab_a[1].instr; a_in_imm_src = tab_a[1].src;
        @(negedge clk);
        chk("bp_rdy1", 64'(a_in_ready), 64'd1);
        qa.push_back(tab_a[1]);
        @(posedge clk);
        #1;
        a_in_instr = tab_a[3].instr; a_in_imm_src = tab_a[3].src;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_rdy_low", 64'(a_in_ready), 64'd0);
            chk("bp_valid", 64'(a_out_valid), 64'd1);
            chk("bp_hold", 64'(a_out_imm), {32'd0, tab_a[0].imm[31:0]});
        end
        @(posedge clk);
        #1;
        a_out_ready = 1'b1;
        send(0, tab_a[3]);
        chk("bp_rdy_back", 64'(a_in_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("bp_drained", 64'(qa.size()), 64'd0);

        // Reset while FULL+SKID
        a_out_ready = 1'b0;
        send(0, tab_a[0]);
        send(0, tab_a[1]);
        chk("pre_rst_rdy", 64'(a_in_ready), 64'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_valid", 64'(a_out_valid), 64'd0);
        chk("midrst_count", 64'(a_out_count), 64'd0);
        chk("midrst_imm", 64'(a_out_imm), 64'd0);
        qa.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("postrst_rdy", 64'(a_in_ready), 64'd1);
        a_out_ready = 1'b1;
        send(0, tab_a[4]);
        chk("postrst_valid", 64'(a_out_valid), 64'd1);
        chk("postrst_imm", 64'(a_out_imm), {32'd0, tab_a[4].imm[31:0]});
        chk("postrst_count", 64'(a_out_count), 64'd0);

        // CNT_W=4 wrap after 17 transfers
        for (int i = 0; i < 17; i++) begin
            send(2, tab_a[(i % 9)]);
        end
        chk("cnt_16", 64'(c_out_count), 64'd0);
        @(posedge clk);
        #1;
        chk("cnt_17", 64'(c_out_count), 64'd1);

        repeat (3) @(posedge clk);
        #1;
        chk("qa_empty", 64'(qa.size()), 64'd0);
        chk("qb_empty", 64'(qb.size()), 64'd0);
        chk("qc_empty", 64'(qc.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
